mem_arb: RTL and testbench

Two-port line-request arbiter between the L1 instruction cache, the L1 data cache and the single backing-memory port. It accepts level-held line read requests from the I-cache and line read or write-back requests from the D-cache. It grants one requester at a time under round-robin priority, runs the request on the memory port with a req/ack handshake, and returns read data with a one-cycle valid pulse. It sits directly below both caches and above the memory or interconnect.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_if.sv | 57 +++++
 rtl/rr_arb2.sv | 43 ++++
 rtl/mem_arb.sv | 140 ++++++++++++++
 tb/tb_mem_arb.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared constants and types for the I/D line-request arbiter:
//             line geometry, FSM state encoding and the grant-select values.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Line geometry shared with the imem/dmem caches
  localparam int LINE_BLK_LEN = 58;
  localparam int LINE_BITS    = 512;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  // Grant-select values (also the encoding of the round-robin 'last' bit)
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_if
//  Purpose  : Bundle of the I-cache, D-cache and memory-port signals around
//             the arbiter. 'slave' is the arbiter's view; 'master' is the view
//             of the caches plus backing memory that surround it.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int BLK_LEN = LINE_BLK_LEN,
  parameter int LINE    = LINE_BITS
) ();

  // I-cache side
  logic [BLK_LEN-1:0] b_addr_i;
  logic               b_rd_i;
  logic [LINE-1:0]    b_data_i;
  logic               b_dv_i;

  // D-cache side
  logic [BLK_LEN-1:0] b_addr_d;
  logic               b_rd_d;
  logic               b_wr_d;
  logic [LINE-1:0]    b_wdata_d;
  logic [LINE-1:0]    b_data_d;
  logic               b_dv_d;

  // Backing-memory side
  logic               m_req;
  logic               m_we;
  logic [BLK_LEN-1:0] m_addr;
  logic [LINE-1:0]    m_wdata;
  logic [LINE-1:0]    m_rdata;
  logic               m_ack;

  modport slave (
    input  b_addr_i, b_rd_i,
    output b_data_i, b_dv_i,
    input  b_addr_d, b_rd_d, b_wr_d, b_wdata_d,
    output b_data_d, b_dv_d,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport master (
    output b_addr_i, b_rd_i,
    input  b_data_i, b_dv_i,
    output b_addr_d, b_rd_d, b_wr_d, b_wdata_d,
    input  b_data_d, b_dv_d,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-input round-robin picker. On a tie the requester that was
//             not served last wins; 'grant' is meaningful only while 'en' is
//             high, and 'last' only advances on an enabled, non-empty pick.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import mem_arb_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic req_i,
  input  wire logic req_d,
  output logic      grant,
  output logic      last
);

  logic r_last;

  // Pick D when it is alone, or on a tie when I was the previous winner
  always_comb begin
    grant = GNT_I;
    if (req_d && (!req_i || (r_last == GNT_I))) begin
      grant = GNT_D;
    end
  end

  // Remember the winner of every grant decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GNT_I;
    end else if (en && (req_i || req_d)) begin
      r_last <= grant;
    end
  end

  assign last = r_last;

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb
//  Purpose  : Line-request arbiter between the L1 I-cache, the L1 D-cache and
//             a single backing-memory port. One transaction at a time:
//             grant -> memory req/ack -> one-cycle dv pulse -> idle.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int BLK_LEN = LINE_BLK_LEN,
  parameter int LINE    = LINE_BITS
) (
  input  wire logic clk,
  input  wire logic rst,
  mem_arb_if.slave  bus
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;

  logic               w_req_i;
  logic               w_req_d;
  logic               w_any_req;
  logic               w_en;
  logic               w_grant;
  logic               w_last;
  logic               w_take;

  logic               w_m_req;
  logic               w_dv_i;
  logic               w_dv_d;

  logic [BLK_LEN-1:0] r_addr;
  logic               r_we;
  logic [LINE-1:0]    r_wdata;
  logic [LINE-1:0]    r_data_i;
  logic [LINE-1:0]    r_data_d;

  assign w_req_i   = bus.b_rd_i;
  assign w_req_d   = bus.b_rd_d | bus.b_wr_d;
  assign w_any_req = w_req_i | w_req_d;
  assign w_en      = (r_state == ST_IDLE);
  assign w_take    = w_en & w_any_req;

  // 'last' doubles as the owner of the transaction in flight: it is written
  // with the winner at grant time and not touched again until the next IDLE.
  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en    (w_en),
    .req_i (w_req_i),
    .req_d (w_req_d),
    .grant (w_grant),
    .last  (w_last)
  );

  // FSM state register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; m_req and dv depend on state only
  always_comb begin
    w_state_nxt = r_state;
    w_m_req     = 1'b0;
    w_dv_i      = 1'b0;
    w_dv_d      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = (w_grant == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        w_m_req = 1'b1;
        if (bus.m_ack) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_dv_i      = (w_last == GNT_I);
        w_dv_d      = (w_last == GNT_D);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the winner's request so the memory port is stable during BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_take) begin
      if (w_grant == GNT_D) begin
        r_addr  <= bus.b_addr_d;
        r_we    <= bus.b_wr_d;
        r_wdata <= bus.b_wdata_d;
      end else begin
        r_addr  <= bus.b_addr_i;
        r_we    <= 1'b0;
      end
    end
  end

  // Capture read data into the owner's line register; writes leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_i <= '0;
      r_data_d <= '0;
    end else if (bus.m_ack && !r_we) begin
      if (r_state == ST_BUSY_I) begin
        r_data_i <= bus.m_rdata;
      end
      if (r_state == ST_BUSY_D) begin
        r_data_d <= bus.m_rdata;
      end
    end
  end

  assign bus.m_req    = w_m_req;
  assign bus.m_we     = r_we;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.b_dv_i   = w_dv_i;
  assign bus.b_dv_d   = w_dv_d;
  assign bus.b_data_i = r_data_i;
  assign bus.b_data_d = r_data_d;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb
//  Purpose  : Self-checking bench for mem_arb: directed scenarios with literal
//             expectations, then randomized cache/memory traffic compared each
//             cycle against a transaction-level model of the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int BLK_LEN = LINE_BLK_LEN;
  localparam int LINE    = LINE_BITS;

  logic clk = 1'b0;
  logic rst;
  logic cmp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_arb_if #(.BLK_LEN(BLK_LEN), .LINE(LINE)) bus ();

  mem_arb #(.BLK_LEN(BLK_LEN), .LINE(LINE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE-1:0] rnd_line();
    logic [LINE-1:0] v;
    for (int k = 0; k < LINE / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BLK_LEN-1:0] rnd_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[BLK_LEN-1:0];
  endfunction

  // ---------------- transaction-level reference model ----------------
  // busy  : a memory transaction is outstanding for 'owner' (1 = D)
  // resp  : the completion pulse for 'owner' is due this cycle
  // last  : who was served most recently (1 = D); a tie goes to the other one
  logic               mdl_busy, mdl_resp, mdl_owner, mdl_last, mdl_we;
  logic [BLK_LEN-1:0] mdl_addr;
  logic [LINE-1:0]    mdl_wdata, exp_di, exp_dd;
  logic               want_i, want_d, mdl_pick_d;

  assign want_i     = bus.b_rd_i;
  assign want_d     = bus.b_rd_d | bus.b_wr_d;
  assign mdl_pick_d = want_d && !(want_i && mdl_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_busy  <= 1'b0;
      mdl_resp  <= 1'b0;
      mdl_owner <= 1'b0;
      mdl_last  <= 1'b0;
      mdl_we    <= 1'b0;
      mdl_addr  <= '0;
      mdl_wdata <= '0;
      exp_di    <= '0;
      exp_dd    <= '0;
    end else if (mdl_resp) begin
      mdl_resp <= 1'b0;
    end else if (mdl_busy) begin
      if (bus.m_ack) begin
        mdl_busy <= 1'b0;
        mdl_resp <= 1'b1;
        if (!mdl_we) begin
          if (mdl_owner) exp_dd <= bus.m_rdata;
          else           exp_di <= bus.m_rdata;
        end
      end
    end else if (want_i || want_d) begin
      mdl_busy  <= 1'b1;
      mdl_owner <= mdl_pick_d;
      mdl_last  <= mdl_pick_d;
      mdl_addr  <= mdl_pick_d ? bus.b_addr_d : bus.b_addr_i;
      mdl_we    <= mdl_pick_d & bus.b_wr_d;
      mdl_wdata <= bus.b_wdata_d;
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_m_req", bus.m_req, mdl_busy);
      if (mdl_busy) begin
        chk("cyc_m_addr", bus.m_addr, mdl_addr);
        chk("cyc_m_we", bus.m_we, mdl_we);
        if (mdl_we) chk("cyc_m_wdata", bus.m_wdata, mdl_wdata);
      end
      chk("cyc_dv_i", bus.b_dv_i, mdl_resp && !mdl_owner);
      chk("cyc_dv_d", bus.b_dv_d, mdl_resp && mdl_owner);
      chk("cyc_data_i", bus.b_data_i, exp_di);
      chk("cyc_data_d", bus.b_data_d, exp_dd);
    end
  end

  // Wait (bounded) for m_req; a timeout counts as a failed comparison
  task automatic wait_mreq(input string name, output bit ok);
    int n;
    n = 0;
    while (!bus.m_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.m_req;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: m_req never rose, got 0, expected 1", name);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [LINE-1:0]    lit_di, lit_dd, pat, pat2;
  logic [BLK_LEN-1:0] grant_seq [4];
  bit                 ok, hold_i, hold_d;
  int                 n_done;

  initial begin
    bus.b_rd_i = 0; bus.b_addr_i = '0;
    bus.b_rd_d = 0; bus.b_wr_d = 0; bus.b_addr_d = '0; bus.b_wdata_d = '0;
    bus.m_rdata = '0; bus.m_ack = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset values
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_dv_i", bus.b_dv_i, 0);
    chk("rst_dv_d", bus.b_dv_d, 0);
    chk("rst_data_i", bus.b_data_i, 0);
    chk("rst_data_d", bus.b_data_d, 0);
    lit_di = '0; lit_dd = '0;

    // Simultaneous requests after reset: D, I, D, I
    grant_seq[0] = 'h50; grant_seq[1] = 'h40; grant_seq[2] = 'h50; grant_seq[3] = 'h40;
    bus.b_addr_i = 'h40; bus.b_rd_i = 1;
    bus.b_addr_d = 'h50; bus.b_rd_d = 1;
    for (int g = 0; g < 4; g++) begin
      wait_mreq("tie_wait", ok);
      if (ok) begin
        chk("tie_grant_addr", bus.m_addr, grant_seq[g]);
        pat = rnd_line();
        bus.m_ack = 1; bus.m_rdata = pat;
        @(negedge clk);
        bus.m_ack = 0;
        if ((g % 2) == 0) begin chk("tie_dv_d", bus.b_dv_d, 1); lit_dd = pat; end
        else              begin chk("tie_dv_i", bus.b_dv_i, 1); lit_di = pat; end
      end
    end
    bus.b_rd_i = 0; bus.b_rd_d = 0;
    repeat (2) @(negedge clk);

    // I-only read: request at cycle 0, ack at cycle 3, dv at cycle 4
    pat = rnd_line();
    bus.b_addr_i = 'h10; bus.b_rd_i = 1;
    chk("ird_c0_m_req", bus.m_req, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("ird_m_req", bus.m_req, 1);
      chk("ird_m_addr", bus.m_addr, 'h10);
      chk("ird_m_we", bus.m_we, 0);
      chk("ird_dv_i_early", bus.b_dv_i, 0);
    end
    bus.m_ack = 1; bus.m_rdata = pat;
    @(negedge clk);
    bus.m_ack = 0;
    chk("ird_dv_i", bus.b_dv_i, 1);
    chk("ird_data_i", bus.b_data_i, pat);
    chk("ird_dv_d", bus.b_dv_d, 0);
    chk("ird_m_req_resp", bus.m_req, 0);
    lit_di = pat;
    bus.b_rd_i = 0;
    @(negedge clk);
    chk("ird_dv_i_once", bus.b_dv_i, 0);
    @(negedge clk);
    chk("ird_no_regrant", bus.m_req, 0);

    // D write-back
    pat = rnd_line();
    bus.b_addr_d = 'h22; bus.b_wdata_d = pat; bus.b_wr_d = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("dwb_m_req", bus.m_req, 1);
      chk("dwb_m_we", bus.m_we, 1);
      chk("dwb_m_addr", bus.m_addr, 'h22);
      chk("dwb_m_wdata", bus.m_wdata, pat);
    end
    bus.m_ack = 1; bus.m_rdata = rnd_line();
    @(negedge clk);
    bus.m_ack = 0;
    chk("dwb_dv_d", bus.b_dv_d, 1);
    chk("dwb_dv_i", bus.b_dv_i, 0);
    chk("dwb_data_d_kept", bus.b_data_d, lit_dd);
    bus.b_wr_d = 0;
    @(negedge clk);
    chk("dwb_dv_d_once", bus.b_dv_d, 0);
    chk("dwb_data_d_kept2", bus.b_data_d, lit_dd);

    // Back-to-back I: re-request in the cycle after dv, m_req at ack+3
    bus.b_addr_i = 'h30; bus.b_rd_i = 1;
    @(negedge clk);
    chk("b2b_m_req1", bus.m_req, 1);
    pat = rnd_line();
    bus.m_ack = 1; bus.m_rdata = pat;            // ack cycle M
    @(negedge clk);                              // M+1
    bus.m_ack = 0;
    chk("b2b_dv_i1", bus.b_dv_i, 1);
    chk("b2b_data_i1", bus.b_data_i, pat);
    bus.b_addr_i = 'h31;
    @(negedge clk);                              // M+2
    chk("b2b_m_req_m2", bus.m_req, 0);
    @(negedge clk);                              // M+3
    chk("b2b_m_req_m3", bus.m_req, 1);
    chk("b2b_m_addr", bus.m_addr, 'h31);
    pat2 = rnd_line();
    bus.m_ack = 1; bus.m_rdata = pat2;
    @(negedge clk);
    bus.m_ack = 0;
    chk("b2b_dv_i2", bus.b_dv_i, 1);
    chk("b2b_data_i2", bus.b_data_i, pat2);
    lit_di = pat2;
    bus.b_rd_i = 0;
    @(negedge clk);

    // Spurious ack in IDLE
    bus.m_ack = 1; bus.m_rdata = rnd_line();
    @(negedge clk);
    bus.m_ack = 0;
    chk("spur_m_req", bus.m_req, 0);
    chk("spur_dv_i", bus.b_dv_i, 0);
    chk("spur_dv_d", bus.b_dv_d, 0);
    chk("spur_data_i", bus.b_data_i, lit_di);
    chk("spur_data_d", bus.b_data_d, lit_dd);
    @(negedge clk);
    chk("spur_m_req2", bus.m_req, 0);

    // Async reset while in BUSY_D
    bus.b_addr_d = 'h66; bus.b_wdata_d = rnd_line(); bus.b_wr_d = 1;
    @(negedge clk);
    chk("arst_busy", bus.m_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_req_now", bus.m_req, 0);
    chk("arst_dv_d", bus.b_dv_d, 0);
    chk("arst_dv_i", bus.b_dv_i, 0);
    bus.b_wr_d = 0;
    @(negedge clk);
    chk("arst_hold_m_req", bus.m_req, 0);
    chk("arst_data_i", bus.b_data_i, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_m_req", bus.m_req, 0);
    chk("arst_idle_dv_d", bus.b_dv_d, 0);
    bus.b_addr_i = 'h77; bus.b_rd_i = 1;
    @(negedge clk);
    chk("arst_regrant", bus.m_req, 1);
    chk("arst_regrant_addr", bus.m_addr, 'h77);
    bus.m_ack = 1; bus.m_rdata = rnd_line();
    @(negedge clk);
    bus.m_ack = 0;
    chk("arst_dv_i_after", bus.b_dv_i, 1);
    bus.b_rd_i = 0;
    @(negedge clk);

    // Randomized traffic checked by the model every cycle
    hold_i = 0; hold_d = 0; n_done = 0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      if (hold_i && bus.b_dv_i) begin hold_i = 0; bus.b_rd_i = 0; n_done++; end
      if (hold_d && bus.b_dv_d) begin hold_d = 0; bus.b_rd_d = 0; bus.b_wr_d = 0; n_done++; end
      if (cyc < 3000) begin
        if (!hold_i && ($urandom % 4 == 0)) begin
          hold_i = 1; bus.b_rd_i = 1; bus.b_addr_i = rnd_addr();
        end
        if (!hold_d && ($urandom % 4 == 0)) begin
          hold_d = 1; bus.b_addr_d = rnd_addr();
          if ($urandom % 2 == 0) begin bus.b_wr_d = 1; bus.b_wdata_d = rnd_line(); end
          else                   bus.b_rd_d = 1;
        end
      end
      if (bus.m_req && ($urandom % 3 == 0)) begin
        bus.m_ack = 1; bus.m_rdata = rnd_line();
      end else if (!bus.m_req && ($urandom % 16 == 0)) begin
        bus.m_ack = 1; bus.m_rdata = rnd_line();
      end else begin
        bus.m_ack = 0;
      end
      @(negedge clk);
    end
    bus.m_ack = 0;
    chk("rand_drained", {hold_i, hold_d}, 2'b00);
    checks++;
    if (n_done < 100) begin
      errors++;
      $display("FAIL rand_progress: got %0d completions, expected at least 100", n_done);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
